spi_byte_ctrl: RTL and testbench

- SPI mode-0 master byte engine for the SD-card side of the interface.
- Accepts one byte per start/busy/done handshake, generates sclk from a programmable divider, and shifts mosi out MSB-first while sampling miso.
- Internally sequences two counters: a phase counter that times each sclk half-period, and a bit counter that tracks 8 bits per byte.
- The upstream SD command/data FSM owns it and controls chip-select via keep_cs.

---
 rtl/spi_byte_ctrl.sv | 146 ++++++++++++++
 tb/tb_spi_byte_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_ctrl.sv
// SPI mode-0 master byte engine for the SD-card side.
// Divider-timed sclk, MSB-first shift, chip-select hold via keep_cs.
module spi_byte_ctrl #(
  parameter int DIV_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [DIV_BITS-1:0] clk_div,
  input  logic                start,
  input  logic [7:0]          tx_data,
  input  logic                keep_cs,
  input  logic                miso,
  output logic                busy,
  output logic                done,
  output logic [7:0]          rx_data,
  output logic                sclk,
  output logic                mosi,
  output logic                cs_n
);

  typedef enum logic [2:0] {
    IDLE, SETUP, HIGH, LOW, FINISH
  } state_t;

  localparam logic [DIV_BITS-1:0] ONE =
    {{(DIV_BITS-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [DIV_BITS-1:0] phase_q, phase_d;
  logic [DIV_BITS-1:0] n_q, n_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          tx_q, tx_d;
  logic [7:0]          rxs_q, rxs_d;
  logic [7:0]          rx_q, rx_d;
  logic                keep_q, keep_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                done_q, done_d;
  logic                phase_end;

  // phase_q runs 0..N-1 so N=2^DIV_BITS-1 never wraps
  assign phase_end = (phase_q == n_q - ONE);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + ONE;
    n_d     = n_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rxs_d   = rxs_q;
    rx_d    = rx_q;
    keep_d  = keep_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        if (start) begin
          state_d = SETUP;
          tx_d    = tx_data;
          mosi_d  = tx_data[7];
          n_d     = (clk_div == '0) ? ONE : clk_div;
          keep_d  = keep_cs;
          cs_n_d  = 1'b0;
          bit_d   = 3'd0;
        end
      end
      SETUP, LOW: begin
        if (phase_end) begin
          state_d = HIGH;
          phase_d = '0;
          sclk_d  = 1'b1;
          rxs_d   = {rxs_q[6:0], miso};
        end
      end
      HIGH: begin
        if (phase_end) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          if (bit_q != 3'd7) begin
            state_d = LOW;
            bit_d   = bit_q + 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        if (phase_end) begin
          state_d = IDLE;
          phase_d = '0;
          done_d  = 1'b1;
          rx_d    = rxs_q;
          cs_n_d  = ~keep_q;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      n_q     <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 8'h00;
      rxs_q   <= 8'h00;
      rx_q    <= 8'h00;
      keep_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      n_q     <= n_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rxs_q   <= rxs_d;
      rx_q    <= rx_d;
      keep_q  <= keep_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign rx_data = rx_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_byte_ctrl.sv
// Directed bench for spi_byte_ctrl.
// Card model shifts miso on sclk falling edges.
module tb_spi_byte_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] clk_div;
  logic       start;
  logic [7:0] tx_data;
  logic       keep_cs;
  logic       miso;
  logic       busy, done, sclk, mosi, cs_n;
  logic [7:0] rx_data;

  int checks = 0;
  int failures = 0;

  logic [7:0] miso_byte = 8'h00;
  logic [2:0] miso_idx;

  int          bc, rises, bad, dn, csbad;
  logic [15:0] mseq;

  spi_byte_ctrl #(.DIV_BITS(8)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .clk_div (clk_div),
    .start   (start),
    .tx_data (tx_data),
    .keep_cs (keep_cs),
    .miso    (miso),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sclk    (sclk),
    .mosi    (mosi),
    .cs_n    (cs_n)
  );

  always #5 clk = ~clk;

  always @(negedge sclk or negedge n_rst)
    if (!n_rst) miso_idx <= 3'd7;
    else        miso_idx <= miso_idx - 3'd1;

  assign miso = miso_byte[miso_idx];

  task automatic kick(input logic [7:0] div, input logic [7:0] tx,
                      input logic kc, input logic [7:0] rxb);
    @(negedge clk);
    clk_div   = div;
    tx_data   = tx;
    keep_cs   = kc;
    miso_byte = rxb;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // measure until ndone done pulses; chains a keep_cs=0 byte on done
  task automatic run(input int n, input int midk, input int ndone,
                     input logic [7:0] tx2);
    logic prev_s, prev_b;
    int   len;
    bc = 0; rises = 0; bad = 0; dn = 0; csbad = 0; mseq = '0;
    prev_s = 1'b0; prev_b = 1'b0; len = 0;
    for (int i = 0; i < 20000; i++) begin
      if (busy) begin
        bc++;
        if (prev_b && sclk == prev_s) len++;
        else begin
          if (prev_b && len != n) bad++;
          len = 1;
        end
      end else if (prev_b && len != n) bad++;
      if (sclk && !prev_s) begin
        rises++;
        mseq = {mseq[14:0], mosi};
      end
      start = 1'b0;
      if (i == midk) begin
        start   = 1'b1;
        clk_div = 8'd7;
        tx_data = 8'h00;
      end
      if (done) begin
        dn++;
        if (dn >= ndone) break;
        start   = 1'b1;
        keep_cs = 1'b0;
        tx_data = tx2;
      end
      if (cs_n) csbad++;
      prev_s = sclk;
      prev_b = busy;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int dcount;
    #12;
    checks++;
    if ({busy, done, rx_data, sclk, mosi, cs_n} !== 13'b0_0_00000000_0_0_1) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b",
               {busy, done, rx_data, sclk, mosi, cs_n}, 13'b0_0_00000000_0_0_1);
    end
    @(negedge clk);
    n_rst = 1'b1;
    kick(8'd4, 8'hA5, 1'b0, 8'h3C);
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b1 || cs_n !== 1'b0) begin
      failures++;
      $display("FAIL pre_abort busy=%b cs_n=%b want 1 0", busy, cs_n);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if ({busy, sclk, cs_n, rx_data} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL abort_state busy=%b sclk=%b cs_n=%b rx=%h want 0 0 1 00",
               busy, sclk, cs_n, rx_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    checks++;
    if (dcount !== 0) begin
      failures++;
      $display("FAIL abort_done got=%0d want=0", dcount);
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    kick(8'd1, 8'hA5, 1'b0, 8'h3C);
    run(1, -1, 1, 8'h00);
    checks++;
    if (bc !== 17) begin
      failures++;
      $display("FAIL basic_busy got=%0d want=17", bc);
    end
    checks++;
    if (mseq[7:0] !== 8'hA5 || rises !== 8) begin
      failures++;
      $display("FAIL basic_mosi got=%h rises=%0d want=a5 8", mseq[7:0], rises);
    end
    checks++;
    if (dn !== 1 || rx_data !== 8'h3C || cs_n !== 1'b1) begin
      failures++;
      $display("FAIL basic_done dn=%0d rx=%h cs_n=%b want 1 3c 1",
               dn, rx_data, cs_n);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_divider();
    kick(8'd3, 8'h5A, 1'b0, 8'hC3);
    run(3, -1, 1, 8'h00);
    checks++;
    if (bc !== 51 || bad !== 0 || rises !== 8) begin
      failures++;
      $display("FAIL div3 busy=%0d badphase=%0d rises=%0d want 51 0 8",
               bc, bad, rises);
    end
    checks++;
    if (rx_data !== 8'hC3 || mseq[7:0] !== 8'h5A) begin
      failures++;
      $display("FAIL div3_data rx=%h mosi=%h want c3 5a", rx_data, mseq[7:0]);
    end
    kick(8'd0, 8'h96, 1'b0, 8'h69);
    run(1, -1, 1, 8'h00);
    checks++;
    if (bc !== 17 || bad !== 0 || rx_data !== 8'h69 || mseq[7:0] !== 8'h96) begin
      failures++;
      $display("FAIL div0 busy=%0d bad=%0d rx=%h mosi=%h want 17 0 69 96",
               bc, bad, rx_data, mseq[7:0]);
    end
  endtask

  task automatic test_cs_hold();
    kick(8'd1, 8'hFF, 1'b1, 8'hA5);
    run(1, -1, 2, 8'h00);
    checks++;
    if (dn !== 2 || rises !== 16 || bc !== 34) begin
      failures++;
      $display("FAIL cs_hold_count dn=%0d rises=%0d busy=%0d want 2 16 34",
               dn, rises, bc);
    end
    checks++;
    if (csbad !== 0 || mseq !== 16'hFF00) begin
      failures++;
      $display("FAIL cs_hold_low cs_high_cycles=%0d mosi=%h want 0 ff00",
               csbad, mseq);
    end
    checks++;
    if (cs_n !== 1'b1) begin
      failures++;
      $display("FAIL cs_hold_release cs_n=%b want 1", cs_n);
    end
  endtask

  task automatic test_ignored();
    kick(8'd2, 8'h81, 1'b0, 8'h5A);
    run(2, 10, 1, 8'h00);
    checks++;
    if (bc !== 34 || bad !== 0 || mseq[7:0] !== 8'h81) begin
      failures++;
      $display("FAIL ignored busy=%0d bad=%0d mosi=%h want 34 0 81",
               bc, bad, mseq[7:0]);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rx_data !== 8'h5A) begin
      failures++;
      $display("FAIL ignored_end busy=%b rx=%h want 0 5a", busy, rx_data);
    end
  endtask

  task automatic test_max_div();
    kick(8'd255, 8'h3C, 1'b0, 8'hE7);
    run(255, -1, 1, 8'h00);
    checks++;
    if (bc !== 4335 || bad !== 0 || rises !== 8) begin
      failures++;
      $display("FAIL max_div busy=%0d bad=%0d rises=%0d want 4335 0 8",
               bc, bad, rises);
    end
    checks++;
    if (rx_data !== 8'hE7 || mseq[7:0] !== 8'h3C) begin
      failures++;
      $display("FAIL max_div_data rx=%h mosi=%h want e7 3c",
               rx_data, mseq[7:0]);
    end
  endtask

  initial begin
    n_rst   = 1'b0;
    clk_div = 8'd0;
    start   = 1'b0;
    tx_data = 8'h00;
    keep_cs = 1'b0;
    test_reset();
    test_basic();
    test_divider();
    test_cs_hold();
    test_ignored();
    test_max_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
